// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory block copier: bus widths, memory depth
// and the FSM state encoding used by the top level.
package mem_copy_pkg;

  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 8;
  localparam int LEN_W     = 13;
  localparam int SUM_W     = 16;
  localparam int MEM_DEPTH = 8192;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    CSUM_LO,
    CSUM_HI,
    DONE
  } state_t;

endpackage

// File: rtl/mem_copy_sum_acc.sv
// Byte-sum accumulator for the block copier. Adds each zero-extended data
// byte into a SUM_W-bit running total that wraps modulo 2^SUM_W.
module mem_copy_sum_acc
  import mem_copy_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add_en,
  input  logic [DATA_W-1:0] din,
  output logic [SUM_W-1:0]  sum
);

  // Accumulate; clear has priority so every new copy starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    if (!rst) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + {{(SUM_W-DATA_W){1'b0}}, din};
    end
  end

endmodule

// File: rtl/mem_block_copier.sv
// Memory block copier: on a start pulse, copies `length` bytes from src_addr
// to dst_addr one byte at a time (READ then WRITE) and keeps a running byte
// sum. Defining MEM_COPY_CSUM_WB_EN appends the 16-bit sum little-endian
// after the copied block.
module mem_block_copier
  import mem_copy_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  count;
  logic [DATA_W-1:0] byte_buf;
  logic              accept;

  // start is honoured only while idle; everywhere else it is ignored.
  assign accept = (state == IDLE) && start;

  mem_copy_sum_acc u_sum_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .add_en (state == READ),
    .din    (mem_rdata),
    .sum    (sum)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pointers, remaining-byte counter and the byte carried from READ to WRITE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_ptr  <= '0;
      dst_ptr  <= '0;
      count    <= '0;
      byte_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr <= src_addr;
            dst_ptr <= dst_addr;
            count   <= length;
          end
        end
        READ: begin
          byte_buf <= mem_rdata;
          src_ptr  <= src_ptr + 1'b1;
        end
        WRITE: begin
          dst_ptr <= dst_ptr + 1'b1;
          count   <= count - 1'b1;
        end
`ifdef MEM_COPY_CSUM_WB_EN
        CSUM_LO: begin
          dst_ptr <= dst_ptr + 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Next-state logic and memory-port drive, decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (length != '0) ? READ : DONE;
        end
      end
      READ: begin
        busy       = 1'b1;
        mem_addr   = src_ptr;
        state_next = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_addr  = dst_ptr;
        mem_wdata = byte_buf;
        mem_we    = 1'b1;
        if (count == LEN_W'(1)) begin
`ifdef MEM_COPY_CSUM_WB_EN
          state_next = CSUM_LO;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = READ;
        end
      end
`ifdef MEM_COPY_CSUM_WB_EN
      CSUM_LO: begin
        busy       = 1'b1;
        mem_addr   = dst_ptr;
        mem_wdata  = sum[DATA_W-1:0];
        mem_we     = 1'b1;
        state_next = CSUM_HI;
      end
      CSUM_HI: begin
        busy       = 1'b1;
        mem_addr   = dst_ptr;
        mem_wdata  = sum[SUM_W-1:DATA_W];
        mem_we     = 1'b1;
        state_next = DONE;
      end
`endif
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_block_copier.sv
// Directed testbench for mem_block_copier with a behavioural 8K x 8 memory.
// Honours MEM_COPY_CSUM_WB_EN for latency and checksum-writeback checks.
`timescale 1ns/1ps
module tb_mem_block_copier;
  import mem_copy_pkg::*;

`ifdef MEM_COPY_CSUM_WB_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              busy;
  logic              done;
  logic [SUM_W-1:0]  sum;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;

  logic [7:0]  mem [0:MEM_DEPTH-1];
  logic        bd_we = 1'b0;
  logic [12:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  int checks = 0;
  int errors = 0;

  logic [7:0] tbl [0:9] = '{8'h0A, 8'h0E, 8'h02, 8'h0F, 8'h03,
                            8'h01, 8'h1A, 8'h0E, 8'h0A, 8'h01};

  mem_block_copier dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we)
  );

  always #5 clk = ~clk;

  // Single-port memory: combinational read, write on the rising edge; the
  // backdoor port preloads contents while the copier is not writing.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    bd_we   = 1'b1;
    bd_addr = a[12:0];
    bd_data = d;
    tick();
    bd_we   = 1'b0;
  endtask

  function automatic logic [31:0] rd(input int a);
    logic [12:0] ad;
    ad = a[12:0];
    return 32'(mem[ad]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch a copy and follow it to the cycle after done. Reports the cycle
  // (counted from the start edge) in which done was seen, the number of
  // cycles with mem_we high, and whether busy was high every cycle before done
  // and low during done. With harass set, conflicting start pulses are sent
  // in cycle 3 and in the done cycle.
  task automatic run_copy(input int s, input int d, input int l, input bit harass,
                          output int done_cyc, output int we_cnt, output bit busy_ok);
    src_addr = s[12:0];
    dst_addr = d[12:0];
    length   = l[12:0];
    start    = 1'b1;
    tick();
    start    = 1'b0;
    src_addr = 13'h0AAA;
    dst_addr = 13'h1555;
    length   = 13'd7;
    done_cyc = -1;
    we_cnt   = 0;
    busy_ok  = 1'b1;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      if (harass && cyc == 3) begin
        start = 1'b1; src_addr = 13'd5; dst_addr = 13'd7000; length = 13'd1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cyc = cyc;
        if (busy) busy_ok = 1'b0;
        if (harass) begin
          start = 1'b1; src_addr = 13'd5; dst_addr = 13'd7000; length = 13'd1;
        end
        tick();
        start = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (mem_we) we_cnt++;
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    int          dc;
    int          wc;
    bit          bo;
    logic [15:0] exp_sum;

    #1 rst = 1'b0;

    // Preload memory while reset is held.
    for (int i = 0; i < 10; i++) poke(1000 + i, tbl[i]);
    poke(5, 8'h55);
    poke(6, 8'h66);
    poke(8190, 8'h11);
    poke(8191, 8'h22);
    poke(0, 8'h33);
    poke(1, 8'h44);
    for (int i = 0; i < 300; i++) poke(3000 + i, 8'hFF);
    poke(7000, 8'h5A);
    for (int i = 0; i < 10; i++) poke(5000 + i, 8'hEE);

    // Reset state.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b1;
    tick();
    tick();

    // Ten-byte copy.
    exp_sum = '0;
    for (int i = 0; i < 10; i++) exp_sum = exp_sum + 16'(tbl[i]);
    run_copy(1000, 2000, 10, 1'b0, dc, wc, bo);
    check("t1_done_cycle", 32'(dc), 32'(21 + EXTRA));
    check("t1_busy", 32'(bo), 32'd1);
    check("t1_we_count", 32'(wc), 32'(10 + EXTRA));
    check("t1_sum", 32'(sum), 32'(exp_sum));
    for (int i = 0; i < 10; i++)
      check($sformatf("t1_byte%0d", i), rd(2000 + i), 32'(tbl[i]));
`ifdef MEM_COPY_CSUM_WB_EN
    check("t1_csum_lo", rd(2010), 32'(exp_sum[7:0]));
    check("t1_csum_hi", rd(2011), 32'(exp_sum[15:8]));
`endif

    // Zero-length request.
    run_copy(5, 6, 0, 1'b0, dc, wc, bo);
    check("t2_done_cycle", 32'(dc), 32'd1);
    check("t2_we_count", 32'(wc), 32'd0);
    check("t2_sum", 32'(sum), 32'd0);
    check("t2_mem5", rd(5), 32'h55);
    check("t2_mem6", rd(6), 32'h66);

    // Source wraps 8191 -> 0.
    run_copy(8190, 100, 4, 1'b0, dc, wc, bo);
    check("t3_done_cycle", 32'(dc), 32'(9 + EXTRA));
    check("t3_sum", 32'(sum), 32'h00AA);
    check("t3_b0", rd(100), 32'h11);
    check("t3_b1", rd(101), 32'h22);
    check("t3_b2", rd(102), 32'h33);
    check("t3_b3", rd(103), 32'h44);

    // Start pulses while busy and during done are ignored.
    run_copy(1000, 2500, 3, 1'b1, dc, wc, bo);
    check("t4_done_cycle", 32'(dc), 32'(7 + EXTRA));
    check("t4_busy", 32'(bo), 32'd1);
    check("t4_sum", 32'(sum), 32'h001A);
    check("t4_b0", rd(2500), 32'h0A);
    check("t4_b1", rd(2501), 32'h0E);
    check("t4_b2", rd(2502), 32'h02);
    check("t4_untouched", rd(7000), 32'h5A);

    // Start in the cycle right after done is accepted.
    run_copy(1003, 2600, 2, 1'b0, dc, wc, bo);
    check("t5_done_cycle", 32'(dc), 32'(5 + EXTRA));
    check("t5_sum", 32'(sum), 32'h0012);
    check("t5_b0", rd(2600), 32'h0F);
    check("t5_b1", rd(2601), 32'h03);

    // Sum wraps modulo 65536.
    run_copy(3000, 4000, 300, 1'b0, dc, wc, bo);
    check("t6_done_cycle", 32'(dc), 32'(601 + EXTRA));
    check("t6_sum", 32'(sum), 32'h2AD4);
    check("t6_first", rd(4000), 32'hFF);
    check("t6_last", rd(4299), 32'hFF);

    // Reset during the write of byte index 3 of a ten-byte copy.
    src_addr = 13'd1000;
    dst_addr = 13'd5000;
    length   = 13'd10;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("t7_pre_we", 32'(mem_we), 32'd1);
    check("t7_pre_addr", 32'(mem_addr), 32'd5003);
    #2 rst = 1'b0;
    #1;
    check("t7_we", 32'(mem_we), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_done", 32'(done), 32'd0);
    check("t7_sum", 32'(sum), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("t7_copied%0d", i), rd(5000 + i), 32'(tbl[i]));
    for (int i = 3; i < 10; i++)
      check($sformatf("t7_kept%0d", i), rd(5000 + i), 32'hEE);

    // A fresh copy after reset release.
    run_copy(8190, 6000, 4, 1'b0, dc, wc, bo);
    check("t8_done_cycle", 32'(dc), 32'(9 + EXTRA));
    check("t8_sum", 32'(sum), 32'h00AA);
    check("t8_b0", rd(6000), 32'h11);
    check("t8_b3", rd(6003), 32'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
